uart_mem_loader: RTL

UART_MEM_LOADER -- requirements
Module: uart_mem_loader

---
 rtl/uart_mem_loader.sv | 337 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_mem_loader.sv
// uart_mem_loader
//   Loads a memory image received over a UART into a word-addressed memory,
//   then hands memory to the CPU (recv_done). A rising edge on the mem2uart
//   switch afterwards dumps the same WORDS words back out over the UART.
//
//   Optional feature: define UART_LOADER_CHECKSUM_EN to expect one extra byte
//   after the image. That byte must equal the modulo-256 sum of all image
//   bytes, otherwise frame_err is set and the whole image is reloaded.
//
// Parameters
//   DATA_W        memory word width (multiple of 8, 8..64)
//   ADDR_W        width of o_addr
//   WORDS         number of words loaded and dumped
//   BASE_ADDR     byte address of word 0 (words are spaced 4 bytes apart)
//   CLKS_PER_BIT  clk cycles per UART bit (>= 4)
//
// Ports
//   clk        single clock, rising edge
//   reset      asynchronous, active-low
//   Rx_Serial  UART receive line (idle high, asynchronous)
//   Tx_Serial  UART transmit line (idle high)
//   mem2uart   dump request switch (asynchronous level)
//   o_addr     memory byte address
//   wr_en      one-cycle memory write strobe
//   wdata      memory write data
//   rdata      memory read data, combinational from o_addr
//   recv_done  image loaded; CPU owns memory while high
//   send_done  dump complete
//   frame_err  sticky: stop bit sampled low (or checksum mismatch)
module uart_mem_loader #(
  parameter int          DATA_W       = 32,
  parameter int          ADDR_W       = 32,
  parameter int          WORDS        = 256,
  parameter logic [63:0] BASE_ADDR    = 64'd0,
  parameter int          CLKS_PER_BIT = 868
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Rx_Serial,
  output logic              Tx_Serial,
  input  logic              mem2uart,
  output logic [ADDR_W-1:0] o_addr,
  output logic              wr_en,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic              recv_done,
  output logic              send_done,
  output logic              frame_err
);

  localparam int              BYTES     = DATA_W / 8;
  localparam int              CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]      LAST_BYTE = 3'(BYTES - 1);
  localparam logic [ADDR_W-1:0] BASE    = BASE_ADDR[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(WORDS - 1);

`ifdef UART_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {LOAD, WRITE, CHECK, DONE, DUMP_RD, DUMP_TX, DUMP_END} state_t;
  localparam state_t LOAD_NEXT = CHECK;
`else
  typedef enum logic [2:0] {LOAD, WRITE, DONE, DUMP_RD, DUMP_TX, DUMP_END} state_t;
  localparam state_t LOAD_NEXT = DONE;
`endif

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] i);
    return BASE + (i << 2);
  endfunction

  // ---------------------------------------------------------------------
  // Input synchronizers (line idles high, switch idles low)
  // ---------------------------------------------------------------------
  logic rx_meta, rx_s, rx_prev;
  logic sw_meta, sw_s, sw_prev;
  logic sw_rise;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
      sw_meta <= 1'b0;
      sw_s    <= 1'b0;
      sw_prev <= 1'b0;
    end else begin
      rx_meta <= Rx_Serial;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
      sw_meta <= mem2uart;
      sw_s    <= sw_meta;
      sw_prev <= sw_s;
    end
  end

  assign sw_rise = sw_s & ~sw_prev;

  // ---------------------------------------------------------------------
  // UART receiver
  // ---------------------------------------------------------------------
  rx_state_t     rx_state, rx_state_n;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]    rx_bit, rx_bit_n;
  logic [7:0]    rx_shift, rx_shift_n;
  logic          rx_valid;
  logic          rx_ferr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_valid   = 1'b0;
    rx_ferr    = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_prev && !rx_s) begin
          rx_state_n = RX_START;
          rx_cnt_n   = '0;
        end
      end
      RX_START: begin
        // A start bit that is no longer low at mid-bit was a glitch.
        if (rx_cnt == CNT_HALF) begin
          rx_cnt_n   = '0;
          rx_bit_n   = '0;
          rx_state_n = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_n = rx_cnt + CW'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt == CNT_LAST) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_s, rx_shift[7:1]};
          rx_bit_n   = rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state_n = RX_STOP;
        end else begin
          rx_cnt_n = rx_cnt + CW'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt == CNT_LAST) begin
          rx_cnt_n   = '0;
          rx_state_n = RX_IDLE;
          if (rx_s) rx_valid = 1'b1;
          else      rx_ferr  = 1'b1;
        end else begin
          rx_cnt_n = rx_cnt + CW'(1);
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Main control FSM
  // ---------------------------------------------------------------------
  state_t              state, state_n;
  logic [ADDR_W-1:0]   idx;
  logic [2:0]          byte_idx;
  logic [CW-1:0]       tx_cnt;
  logic [3:0]          tx_bit;
  logic [2:0]          tx_byte;
  logic [DATA_W-1:0]   tx_word;
  logic                tx_q;
  logic                tx_frame_end;
  logic                tx_next_bit;
  logic                csum_ok;

`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0] csum;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      csum <= '0;
    end else if (rx_valid) begin
      if (state == LOAD)             csum <= csum + rx_shift;
      else if (state == CHECK && !csum_ok) csum <= '0;
    end
  end

  assign csum_ok = (rx_shift == csum);
`else
  assign csum_ok = 1'b1;
`endif

  assign tx_frame_end = (tx_cnt == CNT_LAST) && (tx_bit == 4'd9);
  // Bit after the current one: data bit tx_bit (0..7) or the stop bit.
  assign tx_next_bit  = (tx_bit == 4'd8) ? 1'b1 : tx_word[tx_bit[2:0]];
  assign Tx_Serial    = tx_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= LOAD;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    wr_en     = 1'b0;
    recv_done = 1'b0;
    case (state)
      LOAD: begin
        if (rx_valid && byte_idx == LAST_BYTE) state_n = WRITE;
      end
      WRITE: begin
        wr_en   = 1'b1;
        state_n = (idx == LAST_IDX) ? LOAD_NEXT : LOAD;
      end
`ifdef UART_LOADER_CHECKSUM_EN
      CHECK: begin
        if (rx_valid) state_n = csum_ok ? DONE : LOAD;
      end
`endif
      DONE: begin
        recv_done = 1'b1;
        if (sw_rise) state_n = DUMP_RD;
      end
      DUMP_RD: begin
        recv_done = 1'b1;
        state_n   = DUMP_TX;
      end
      DUMP_TX: begin
        recv_done = 1'b1;
        if (tx_frame_end && tx_byte == LAST_BYTE)
          state_n = (idx == LAST_IDX) ? DUMP_END : DUMP_RD;
      end
      DUMP_END: begin
        recv_done = 1'b1;
        state_n   = DONE;
      end
      default: state_n = LOAD;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath: word assembly, addressing, transmitter, status flags
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx       <= '0;
      byte_idx  <= '0;
      o_addr    <= BASE;
      wdata     <= '0;
      send_done <= 1'b0;
      frame_err <= 1'b0;
      tx_q      <= 1'b1;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_byte   <= '0;
      tx_word   <= '0;
    end else begin
      if (rx_ferr) frame_err <= 1'b1;
      case (state)
        LOAD: begin
          if (rx_valid) begin
            wdata[{byte_idx, 3'b000} +: 8] <= rx_shift;
            if (byte_idx == LAST_BYTE) begin
              byte_idx <= '0;
              o_addr   <= word_addr(idx);
            end else begin
              byte_idx <= byte_idx + 3'd1;
            end
          end
        end
        WRITE: idx <= idx + ADDR_W'(1);
`ifdef UART_LOADER_CHECKSUM_EN
        CHECK: begin
          if (rx_valid && !csum_ok) begin
            frame_err <= 1'b1;
            idx       <= '0;
          end
        end
`endif
        DONE: begin
          if (sw_rise) begin
            send_done <= 1'b0;
            idx       <= '0;
            o_addr    <= BASE;
          end
        end
        DUMP_RD: begin
          // o_addr was set on entry, so rdata is valid this cycle.
          tx_word <= rdata;
          tx_q    <= 1'b0;
          tx_cnt  <= '0;
          tx_bit  <= '0;
          tx_byte <= '0;
        end
        DUMP_TX: begin
          if (tx_cnt == CNT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 4'd9) begin
              tx_bit <= '0;
              if (tx_byte == LAST_BYTE) begin
                tx_q <= 1'b1;
                if (idx != LAST_IDX) begin
                  idx    <= idx + ADDR_W'(1);
                  o_addr <= word_addr(idx + ADDR_W'(1));
                end
              end else begin
                // Next byte starts immediately with its start bit.
                tx_byte <= tx_byte + 3'd1;
                tx_word <= tx_word >> 8;
                tx_q    <= 1'b0;
              end
            end else begin
              tx_bit <= tx_bit + 4'd1;
              tx_q   <= tx_next_bit;
            end
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        DUMP_END: send_done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule
